simon_seq_memory: RTL and testbench

Parametrised successor to the single-port pattern memory. It stores the Simon Says colour sequence and tracks its length. It plays the sequence back through a valid/ready stream and checks player entries against the stored sequence, reporting match, fail and round-complete. It sits between the game FSM (append, start, clear), the LED/tone driver (playback stream) and the button decoder (check stream).

---
 rtl/simon_seq_memory.sv | 157 +++++++++++++++
 tb/tb_simon_seq_memory.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/simon_seq_memory.sv
// rtl/simon_seq_memory.sv - Simon Says sequence store with stream playback and entry checking
module simon_seq_memory #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  append_en,
    input  logic [DATA_WIDTH-1:0] append_data,
    input  logic                  play_start,
    input  logic                  check_start,
    output logic [DATA_WIDTH-1:0] play_data,
    output logic                  play_valid,
    input  logic                  play_ready,
    output logic                  play_last,
    input  logic                  check_en,
    input  logic [DATA_WIDTH-1:0] check_data,
    output logic                  check_ready,
    output logic                  check_match,
    output logic                  check_fail,
    output logic                  check_done,
    output logic [ADDR_WIDTH:0]   length,
    output logic                  full,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, PLAY_RD, PLAY_OUT, CHK_RD, CHK_WAIT} state_t;

    localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_MAX = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic                  match_q, match_d;
    logic                  fail_q, fail_d;
    logic                  done_q, done_d;
    logic                  mem_we;
    logic                  at_last;
    logic                  is_full;

    assign is_full = (len_q == LEN_MAX);
    assign at_last = ({1'b0, idx_q} == (len_q - LEN_ONE));

    // rd_q serves as playback data in PLAY_OUT and as the expected step in CHK_WAIT
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        match_d = 1'b0;
        fail_d  = 1'b0;
        done_d  = 1'b0;
        mem_we  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            len_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (append_en && !is_full) begin
                        mem_we = 1'b1;
                        len_d  = len_q + LEN_ONE;
                    end else if (play_start && len_q != '0) begin
                        state_d = PLAY_RD;
                        idx_d   = '0;
                    end else if (check_start && len_q != '0) begin
                        state_d = CHK_RD;
                        idx_d   = '0;
                    end
                end
                PLAY_RD: begin
                    rd_d    = mem[idx_q];
                    state_d = PLAY_OUT;
                end
                PLAY_OUT: begin
                    if (play_ready) begin
                        if (at_last) begin
                            state_d = IDLE;
                        end else begin
                            idx_d   = idx_q + IDX_ONE;
                            state_d = PLAY_RD;
                        end
                    end
                end
                CHK_RD: begin
                    rd_d    = mem[idx_q];
                    state_d = CHK_WAIT;
                end
                CHK_WAIT: begin
                    if (check_en) begin
                        if (check_data == rd_q) begin
                            match_d = 1'b1;
                            if (at_last) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                idx_d   = idx_q + IDX_ONE;
                                state_d = CHK_RD;
                            end
                        end else begin
                            fail_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            rd_q    <= '0;
            match_q <= 1'b0;
            fail_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            match_q <= match_d;
            fail_q  <= fail_d;
            done_q  <= done_d;
        end
    end

    // Storage is deliberately left unreset; length alone defines what is reachable
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[len_q[ADDR_WIDTH-1:0]] <= append_data;
        end
    end

    assign play_data   = rd_q;
    assign play_valid  = (state_q == PLAY_OUT);
    assign play_last   = (state_q == PLAY_OUT) && at_last;
    assign check_ready = (state_q == CHK_WAIT);
    assign check_match = match_q;
    assign check_fail  = fail_q;
    assign check_done  = done_q;
    assign length      = len_q;
    assign full        = is_full;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_simon_seq_memory.sv
// tb/tb_simon_seq_memory.sv - scoreboard bench for simon_seq_memory
module tb_simon_seq_memory;
    localparam int DW    = 6;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n, clear, append_en, play_start, check_start;
    logic [DW-1:0] append_data, play_data, check_data;
    logic          play_valid, play_ready, play_last;
    logic          check_en, check_ready, check_match, check_fail, check_done;
    logic [AW:0]   length;
    logic          full, busy;

    simon_seq_memory #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .append_en(append_en), .append_data(append_data),
        .play_start(play_start), .check_start(check_start),
        .play_data(play_data), .play_valid(play_valid), .play_ready(play_ready),
        .play_last(play_last), .check_en(check_en), .check_data(check_data),
        .check_ready(check_ready), .check_match(check_match), .check_fail(check_fail),
        .check_done(check_done), .length(length), .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int data; int last; } play_item_t;
    typedef struct { int m; int f; int d; } chk_item_t;

    int         checks = 0;
    int         passes = 0;
    int         model[$];
    int         entries[$];
    play_item_t play_exp[$];
    chk_item_t  chk_exp[$];

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every handshake/pulse and checks stream rules
    initial begin : monitor
        logic       prev_stall, prev_hs, prev_cen, prev_clear;
        int         prev_data;
        play_item_t pi;
        chk_item_t  ci;
        prev_stall = 0; prev_hs = 0; prev_cen = 0; prev_clear = 0; prev_data = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_stall && !prev_clear) begin
                    check_eq("play_hold_valid", int'(play_valid), 1);
                    check_eq("play_hold_data", int'(play_data), prev_data);
                end
                if (prev_hs) check_eq("play_bubble", int'(play_valid), 0);
                if (play_valid && play_ready && !clear) begin
                    if (play_exp.size() == 0) begin
                        checks++;
                        $display("FAIL play_unexpected: got data %0d expected no beat", play_data);
                    end else begin
                        pi = play_exp.pop_front();
                        check_eq("play_data", int'(play_data), pi.data);
                        check_eq("play_last", int'(play_last), pi.last);
                    end
                end
                if (check_match || check_fail || check_done) begin
                    check_eq("pulse_timing", int'(prev_cen), 1);
                    if (chk_exp.size() == 0) begin
                        checks++;
                        $display("FAIL check_unexpected: got m%0d f%0d d%0d expected none",
                                 check_match, check_fail, check_done);
                    end else begin
                        ci = chk_exp.pop_front();
                        check_eq("check_match", int'(check_match), ci.m);
                        check_eq("check_fail", int'(check_fail), ci.f);
                        check_eq("check_done", int'(check_done), ci.d);
                    end
                end
            end
            prev_stall = rst_n && play_valid && !play_ready && !clear;
            prev_hs    = rst_n && play_valid && play_ready && !clear;
            prev_cen   = rst_n && check_en && check_ready && !clear;
            prev_clear = clear;
            prev_data  = play_data;
        end
    end

    task automatic do_append(input int d);
        append_en = 1; append_data = DW'(d);
        tick();
        append_en = 0;
        if (model.size() < DEPTH) model.push_back(d);
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
        model.delete();
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 4 cycles on stall_data
    task automatic do_play(input int mode, input int stall_data);
        int stalls = 0;
        for (int i = 0; i < model.size(); i++)
            play_exp.push_back('{data: model[i], last: int'(i == model.size() - 1)});
        play_ready = (mode == 0); play_start = 1;
        tick();
        play_start = 0;
        for (int n = 0; n < 2000 && busy; n++) begin
            if (mode == 0) play_ready = 1;
            else if (mode == 1) play_ready = 1'($urandom_range(0, 1));
            else if (play_valid && int'(play_data) == stall_data && stalls < 4) begin
                play_ready = 0; stalls++;
            end else play_ready = 1;
            tick();
        end
        play_ready = 0;
        check_eq("play_end_busy", int'(busy), 0);
        check_eq("play_queue_drained", play_exp.size(), 0);
    endtask

    task automatic do_check();
        bit mism;
        check_start = 1;
        tick();
        check_start = 0;
        foreach (entries[i]) begin
            for (int n = 0; n < 100 && !check_ready; n++) begin
                check_en = 1'($urandom_range(0, 1)); check_data = DW'($urandom);
                tick();
            end
            check_en = 0;
            check_eq("check_ready_up", int'(check_ready), 1);
            repeat ($urandom_range(0, 2)) tick();
            mism = (entries[i] != model[i]);
            chk_exp.push_back('{m: int'(!mism), f: int'(mism),
                                d: int'(!mism && i == model.size() - 1)});
            check_en = 1; check_data = DW'(entries[i]);
            tick();
            check_en = 0;
            if (mism) break;
        end
        for (int n = 0; n < 100 && busy; n++) tick();
        tick();
        check_eq("check_end_busy", int'(busy), 0);
        check_eq("check_queue_drained", chk_exp.size(), 0);
        check_eq("len_after_check", int'(length), model.size());
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 0; clear = 0; append_en = 0; append_data = 0; play_start = 0;
        check_start = 0; play_ready = 0; check_en = 0; check_data = 0;
        repeat (3) tick();
        check_eq("rst_length", int'(length), 0);
        check_eq("rst_full", int'(full), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_play_valid", int'(play_valid), 0);
        check_eq("rst_play_data", int'(play_data), 0);
        check_eq("rst_check_ready", int'(check_ready), 0);
        check_eq("rst_pulses", int'({check_match, check_fail, check_done}), 0);
        rst_n = 1;
        tick();

        do_append(5); do_append(9); do_append(17);
        check_eq("len3", int'(length), 3);
        check_eq("len3_full", int'(full), 0);
        check_eq("len3_busy", int'(busy), 0);
        check_eq("len3_pulses", int'({check_match, check_fail, check_done}), 0);

        do_play(0, 0);
        do_play(2, 9);
        entries = '{5, 9, 17};
        do_check();
        entries = '{5, 3};
        do_check();

        do_clear();
        check_eq("clear_len", int'(length), 0);
        for (int i = 0; i < DEPTH + 2; i++) do_append($urandom_range(0, 63));
        check_eq("full_len", int'(length), DEPTH);
        check_eq("full_flag", int'(full), 1);
        do_play(1, 0);

        play_ready = 0; play_start = 1;
        tick();
        play_start = 0;
        repeat (3) tick();
        check_eq("midplay_valid", int'(play_valid), 1);
        do_clear();
        check_eq("aclr_valid", int'(play_valid), 0);
        check_eq("aclr_len", int'(length), 0);
        check_eq("aclr_full", int'(full), 0);
        check_eq("aclr_busy", int'(busy), 0);
        play_ready = 1; play_start = 1;
        tick();
        play_start = 0;
        repeat (3) begin
            check_eq("empty_start_busy", int'(busy), 0);
            check_eq("empty_start_valid", int'(play_valid), 0);
            tick();
        end
        play_ready = 0;

        repeat (10) begin
            int n;
            do_clear();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) do_append($urandom_range(0, 63));
            do_play(1, 0);
            entries = model;
            if ($urandom_range(0, 1) == 1) begin
                int k = $urandom_range(0, n - 1);
                entries[k] = model[k] ^ $urandom_range(1, 63);
                while (entries.size() > k + 1) void'(entries.pop_back());
            end
            do_check();
        end

        repeat (2) tick();
        check_eq("final_play_queue", play_exp.size(), 0);
        check_eq("final_check_queue", chk_exp.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
